// File: rtl/dla_hzz_ddr_slave.sv
// dla_hzz_ddr_slave: DDR-side endpoint of the DLA HZZ link.
// The block decodes the word-serial header/address/data stream on hzz_mosi and runs
// burst writes or reads on a single-port memory. Read data returns on hzz_miso.
// Optional build macro: HZZ_SLV_ERR_CNT_EN adds the saturating err_cnt output.
module dla_hzz_ddr_slave #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] hzz_mosi,
    input  logic              hzz_mosi_valid,
    output logic [DATA_W-1:0] hzz_miso,
    output logic              hzz_miso_valid,
    output logic              hzz_mosi_en,
    output logic              hzz_miso_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err_pulse
`ifdef HZZ_SLV_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA
    } state_t;

    state_t            state_reg, state_next;
    logic              is_read_reg, is_read_next;
    logic [8:0]        beats_reg, beats_next;
    logic [8:0]        cnt_reg, cnt_next;
    logic [ADDR_W-1:0] cur_reg, cur_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              mem_ren_reg, mem_ren_next;
    logic              mem_wen_reg, mem_wen_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic              miso_valid_reg, miso_valid_next;
    logic              err_reg, err_next;

    logic [1:0]        opcode;
    logic [8:0]        hdr_beats;

    assign opcode    = hzz_mosi[DATA_W-1 -: 2];
    assign hdr_beats = {1'b0, hzz_mosi[7:0]} + 9'd1;

    // Next-state and datapath decode for the command FSM.
    always_comb begin
        state_next      = state_reg;
        is_read_next    = is_read_reg;
        beats_next      = beats_reg;
        cnt_next        = cnt_reg;
        cur_next        = cur_reg;
        mem_addr_next   = mem_addr_reg;
        mem_ren_next    = 1'b0;
        mem_wen_next    = 1'b0;
        mem_wdata_next  = mem_wdata_reg;
        // Memory data arrives one cycle after the read strobe; valid simply follows it.
        miso_valid_next = mem_ren_reg;
        err_next        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (hzz_mosi_valid) begin
                    if (opcode == OP_WRITE || opcode == OP_READ) begin
                        is_read_next = (opcode == OP_READ);
                        beats_next   = hdr_beats;
                        state_next   = ST_ADDR;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end

            ST_ADDR: begin
                if (hzz_mosi_valid) begin
                    if (is_read_reg) begin
                        // First read strobe is issued in the entry cycle of RDATA.
                        mem_ren_next  = 1'b1;
                        mem_addr_next = hzz_mosi[ADDR_W-1:0];
                        cur_next      = hzz_mosi[ADDR_W-1:0] + ADDR_W'(1);
                        cnt_next      = 9'd1;
                        state_next    = ST_RDATA;
                    end else begin
                        cur_next   = hzz_mosi[ADDR_W-1:0];
                        cnt_next   = 9'd0;
                        state_next = ST_WDATA;
                    end
                end
            end

            ST_WDATA: begin
                if (hzz_mosi_valid) begin
                    mem_wen_next   = 1'b1;
                    mem_wdata_next = hzz_mosi;
                    mem_addr_next  = cur_reg;
                    cur_next       = cur_reg + ADDR_W'(1);
                    cnt_next       = cnt_reg + 9'd1;
                    if (cnt_reg + 9'd1 == beats_reg) begin
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_RDATA: begin
                // The link is turned around; any incoming word is a protocol violation.
                if (hzz_mosi_valid) begin
                    err_next = 1'b1;
                end
                if (cnt_reg != beats_reg) begin
                    mem_ren_next  = 1'b1;
                    mem_addr_next = cur_reg;
                    cur_next      = cur_reg + ADDR_W'(1);
                    cnt_next      = cnt_reg + 9'd1;
                end else if (!mem_ren_reg) begin
                    // Last data beat is on miso this cycle; hand the link back next cycle.
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any burst immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            is_read_reg    <= 1'b0;
            beats_reg      <= 9'd0;
            cnt_reg        <= 9'd0;
            cur_reg        <= '0;
            mem_addr_reg   <= '0;
            mem_ren_reg    <= 1'b0;
            mem_wen_reg    <= 1'b0;
            mem_wdata_reg  <= '0;
            miso_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            is_read_reg    <= is_read_next;
            beats_reg      <= beats_next;
            cnt_reg        <= cnt_next;
            cur_reg        <= cur_next;
            mem_addr_reg   <= mem_addr_next;
            mem_ren_reg    <= mem_ren_next;
            mem_wen_reg    <= mem_wen_next;
            mem_wdata_reg  <= mem_wdata_next;
            miso_valid_reg <= miso_valid_next;
            err_reg        <= err_next;
        end
    end

`ifdef HZZ_SLV_ERR_CNT_EN
    logic [7:0] err_cnt_reg, err_cnt_next;

    // Saturating count of error pulses, updated together with the pulse itself.
    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (err_next && err_cnt_reg != 8'hFF) begin
            err_cnt_next = err_cnt_reg + 8'd1;
        end
    end

    // Error counter register; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_reg <= 8'd0;
        end else begin
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign err_cnt = err_cnt_reg;
`endif

    assign hzz_miso       = miso_valid_reg ? mem_rdata : '0;
    assign hzz_miso_valid = miso_valid_reg;
    assign hzz_miso_en    = (state_reg == ST_RDATA);
    assign hzz_mosi_en    = (state_reg != ST_RDATA);
    assign busy           = (state_reg != ST_IDLE);
    assign mem_addr       = mem_addr_reg;
    assign mem_ren        = mem_ren_reg;
    assign mem_wen        = mem_wen_reg;
    assign mem_wdata      = mem_wdata_reg;
    assign err_pulse      = err_reg;

endmodule

// File: tb/tb_dla_hzz_ddr_slave.sv
// tb_dla_hzz_ddr_slave: self-checking bench for dla_hzz_ddr_slave.
// Directed table of transactions, a mid-burst reset sequence and a randomized phase,
// all checked against a word-addressed reference memory kept in the bench.
module tb_dla_hzz_ddr_slave;

    localparam int DW = 64;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] hzz_mosi = '0;
    logic          hzz_mosi_valid = 1'b0;
    logic [DW-1:0] hzz_miso;
    logic          hzz_miso_valid;
    logic          hzz_mosi_en;
    logic          hzz_miso_en;
    logic [AW-1:0] mem_addr;
    logic          mem_ren;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic          err_pulse;
`ifdef HZZ_SLV_ERR_CNT_EN
    logic [7:0]    err_cnt;
`endif

    int    n_checks = 0;
    int    n_fail   = 0;
    int    exp_err_cnt = 0;
    string tag = "reset";

    // Memory attached to the DUT and the bench's own expectation of its contents.
    logic [DW-1:0] dev_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    always #5 clk = ~clk;

    dla_hzz_ddr_slave #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .hzz_mosi       (hzz_mosi),
        .hzz_mosi_valid (hzz_mosi_valid),
        .hzz_miso       (hzz_miso),
        .hzz_miso_valid (hzz_miso_valid),
        .hzz_mosi_en    (hzz_mosi_en),
        .hzz_miso_en    (hzz_miso_en),
        .mem_addr       (mem_addr),
        .mem_ren        (mem_ren),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .busy           (busy),
        .err_pulse      (err_pulse)
`ifdef HZZ_SLV_ERR_CNT_EN
        ,
        .err_cnt        (err_cnt)
`endif
    );

    // Single-port memory: read data valid exactly one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_wen) dev_mem[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= dev_mem[mem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got 0x%0h, expected 0x%0h", tag, name, act, exp);
        end
    endtask

    task automatic chk_err_cnt();
`ifdef HZZ_SLV_ERR_CNT_EN
        chk("err_cnt", 64'(err_cnt), 64'(exp_err_cnt));
`endif
    endtask

    task automatic check_reset_outputs();
        chk("rst hzz_miso", hzz_miso, 64'h0);
        chk("rst miso_valid", 64'(hzz_miso_valid), 64'h0);
        chk("rst mosi_en", 64'(hzz_mosi_en), 64'h1);
        chk("rst miso_en", 64'(hzz_miso_en), 64'h0);
        chk("rst mem_addr", 64'(mem_addr), 64'h0);
        chk("rst mem_ren", 64'(mem_ren), 64'h0);
        chk("rst mem_wen", 64'(mem_wen), 64'h0);
        chk("rst mem_wdata", mem_wdata, 64'h0);
        chk("rst busy", 64'(busy), 64'h0);
        chk("rst err_pulse", 64'(err_pulse), 64'h0);
        chk_err_cnt();
    endtask

    function automatic logic [63:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 64'h0;
    endfunction

    // One full transaction, driven and checked on falling edges.
    // viol >= 0 drives a stray mosi word during read cycle T+viol.
    task automatic run_txn(input logic [1:0] op, input int n, input logic [AW-1:0] addr,
                           input int gap, input logic [63:0] dbase, input bit rnd,
                           input int viol, input logic exp_err);
        logic [63:0]   hdr;
        logic [63:0]   w;
        logic [AW-1:0] a;
        hdr = '0;
        hdr[63:62] = op;
        hdr[7:0] = 8'(n - 1);
        hzz_mosi = hdr;
        hzz_mosi_valid = 1'b1;
        @(negedge clk);
        chk("err_pulse after header", 64'(err_pulse), 64'(exp_err));
        if (op != 2'b01 && op != 2'b10) begin
            if (exp_err_cnt < 255) exp_err_cnt++;
            chk("busy after bad header", 64'(busy), 64'h0);
            chk("strobes after bad header", 64'({mem_ren, mem_wen}), 64'h0);
            hzz_mosi_valid = 1'b0;
            @(negedge clk);
            chk("err_pulse width", 64'(err_pulse), 64'h0);
            chk("busy after error", 64'(busy), 64'h0);
            chk_err_cnt();
            return;
        end
        chk("busy after header", 64'(busy), 64'h1);
        w = {$urandom, $urandom};
        w[AW-1:0] = addr;
        hzz_mosi = w;
        @(negedge clk);
        if (op == 2'b01) begin
            chk("mosi_en in write", 64'(hzz_mosi_en), 64'h1);
            chk("no wen before data", 64'(mem_wen), 64'h0);
            for (int i = 0; i < n; i++) begin
                w = rnd ? {$urandom, $urandom} : dbase + 64'(i);
                a = addr + AW'(i);
                hzz_mosi = w;
                hzz_mosi_valid = 1'b1;
                @(negedge clk);
                chk("wen", 64'(mem_wen), 64'h1);
                chk("ren during write", 64'(mem_ren), 64'h0);
                chk("write addr", 64'(mem_addr), 64'(a));
                chk("write data", mem_wdata, w);
                chk("busy during write", 64'(busy), 64'(i < n - 1));
                ref_mem[a] = w;
                hzz_mosi_valid = 1'b0;
                hzz_mosi = {$urandom, $urandom};
                if (i < n - 1) begin
                    for (int g = 0; g < gap; g++) begin
                        @(negedge clk);
                        chk("no wen in gap", 64'(mem_wen), 64'h0);
                    end
                end
            end
        end else begin
            // Now in read entry cycle T.
            hzz_mosi_valid = 1'b0;
            for (int k = 0; k <= n + 1; k++) begin
                if (k > 0) @(negedge clk);
                chk("miso_en", 64'(hzz_miso_en), 64'(k <= n));
                chk("mosi_en", 64'(hzz_mosi_en), 64'(k > n));
                chk("busy during read", 64'(busy), 64'(k <= n));
                chk("ren", 64'(mem_ren), 64'(k < n));
                if (k < n) begin
                    a = addr + AW'(k);
                    chk("read addr", 64'(mem_addr), 64'(a));
                end
                chk("miso_valid", 64'(hzz_miso_valid), 64'(k >= 1 && k <= n));
                if (k >= 1 && k <= n) begin
                    a = addr + AW'(k - 1);
                    chk("miso data", hzz_miso, ref_read(a));
                end
                chk("err_pulse in read", 64'(err_pulse), 64'(viol >= 0 && k == viol + 1));
                if (viol >= 0 && k == viol + 1 && exp_err_cnt < 255) exp_err_cnt++;
                hzz_mosi_valid = (k == viol);
                hzz_mosi = {$urandom, $urandom};
            end
            hzz_mosi_valid = 1'b0;
        end
        chk_err_cnt();
    endtask

    // Cycle-by-cycle invariants.
    always @(negedge clk) begin
        if (!rst) begin
            chk("mon ren and wen together", 64'(mem_ren && mem_wen), 64'h0);
            if (!hzz_miso_valid) chk("mon miso idle value", hzz_miso, 64'h0);
            chk("mon enables exclusive", 64'(hzz_mosi_en ^ hzz_miso_en), 64'h1);
        end
    end

    typedef struct {
        logic [1:0]    op;
        int            beats;
        logic [AW-1:0] addr;
        int            gap;
        logic [63:0]   dbase;
        int            viol;
        logic          exp_err;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [1:0]    r_op;
        int            r_n;
        logic [AW-1:0] r_addr;
        int            r_viol;
        int            sel;

        vecs[0]  = '{2'b01,   4, 20'h00010, 0, 64'hA0,   -1, 1'b0};
        vecs[1]  = '{2'b10,   4, 20'h00010, 0, 64'h0,    -1, 1'b0};
        vecs[2]  = '{2'b10,   1, 20'h00005, 0, 64'h0,    -1, 1'b0};
        vecs[3]  = '{2'b01,   3, 20'hFFFFF, 0, 64'hB0,   -1, 1'b0};
        vecs[4]  = '{2'b10,   3, 20'hFFFFF, 0, 64'h0,    -1, 1'b0};
        vecs[5]  = '{2'b11,   1, 20'h00000, 0, 64'h0,    -1, 1'b1};
        vecs[6]  = '{2'b00,   1, 20'h00000, 0, 64'h0,    -1, 1'b1};
        vecs[7]  = '{2'b01,   2, 20'h00100, 3, 64'hC0,   -1, 1'b0};
        vecs[8]  = '{2'b10,   2, 20'h00100, 0, 64'h0,    -1, 1'b0};
        vecs[9]  = '{2'b10,   8, 20'h00010, 0, 64'h0,     2, 1'b0};
        vecs[10] = '{2'b01, 256, 20'h00200, 0, 64'h1000, -1, 1'b0};
        vecs[11] = '{2'b10, 256, 20'h00200, 0, 64'h0,    -1, 1'b0};
        vecs[12] = '{2'b01,   1, 20'h00005, 1, 64'hD0,   -1, 1'b0};
        vecs[13] = '{2'b10,   1, 20'h00005, 0, 64'h0,    -1, 1'b0};

        for (int i = 0; i < (1 << AW); i++) dev_mem[i] = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // Directed table, issued back to back.
        for (int i = 0; i < 14; i++) begin
            tag = $sformatf("vec%0d", i);
            run_txn(vecs[i].op, vecs[i].beats, vecs[i].addr, vecs[i].gap,
                    vecs[i].dbase, 1'b0, vecs[i].viol, vecs[i].exp_err);
        end

        // Reset asserted in cycle T+2 of an 8-beat read.
        tag = "midreset";
        hzz_mosi = {2'b10, 54'h0, 8'd7};
        hzz_mosi_valid = 1'b1;
        @(negedge clk);
        hzz_mosi = 64'h40;
        @(negedge clk);
        hzz_mosi_valid = 1'b0;
        chk("ren at T", 64'(mem_ren), 64'h1);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 exp_err_cnt = 0;
        check_reset_outputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("no ren in reset", 64'(mem_ren), 64'h0);
            chk("no miso_valid in reset", 64'(hzz_miso_valid), 64'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("idle after reset", 64'(busy), 64'h0);
        chk("no ren after reset", 64'(mem_ren), 64'h0);
        tag = "postreset";
        run_txn(2'b01, 2, 20'h00040, 0, 64'hE0, 1'b0, -1, 1'b0);
        run_txn(2'b10, 2, 20'h00040, 0, 64'h0, 1'b0, -1, 1'b0);

        // Randomized transactions against the reference memory.
        for (int t = 0; t < 40; t++) begin
            tag = $sformatf("rnd%0d", t);
            sel = int'($urandom_range(0, 9));
            if (sel == 0) r_op = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'b00;
            else if (sel < 5) r_op = 2'b01;
            else r_op = 2'b10;
            if ($urandom_range(0, 7) == 0) r_n = int'($urandom_range(1, 256));
            else r_n = int'($urandom_range(1, 12));
            if ($urandom_range(0, 1) == 0) r_addr = AW'($urandom_range(0, 63));
            else r_addr = 20'hFFFE0 + AW'($urandom_range(0, 31));
            r_viol = -1;
            if (r_op == 2'b10 && $urandom_range(0, 3) == 0) r_viol = int'($urandom_range(0, r_n));
            run_txn(r_op, r_n, r_addr, int'($urandom_range(0, 2)), 64'h0, 1'b1, r_viol,
                    (r_op == 2'b11 || r_op == 2'b00));
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
